// File: rtl/global_history_predictor.sv
// rtl/global_history_predictor.sv - global-history stage of the tournament branch predictor
// Speculative GHR plus a 2^HIST_BITS table of 2-bit counters, cleared by a sweep after reset.
module global_history_predictor #(
  parameter int HIST_BITS = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 ready,
  input  logic                 pred_req,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [HIST_BITS-1:0] pred_index,
  input  logic                 upd_valid,
  input  logic [HIST_BITS-1:0] upd_index,
  input  logic                 upd_taken,
  input  logic                 upd_mispredict
);

  localparam int ENTRIES = 1 << HIST_BITS;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [HIST_BITS-1:0] sweep_ptr;
  logic [HIST_BITS-1:0] ghr;
  logic [HIST_BITS-1:0] ghr_next;
  logic [1:0]           table_q [ENTRIES];
  logic                 sweep_en;
  logic                 sweep_last;
  logic                 lookup_en;
  logic                 update_en;
  logic                 repair_en;
  logic                 lookup_dir;
  logic [1:0]           upd_ctr;
  logic [1:0]           upd_ctr_next;

  assign sweep_last = (sweep_ptr == '1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:  if (sweep_last) state_next = ST_READY;
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_INIT;
    endcase
  end

  always_comb begin
    ready     = (state == ST_READY);
    sweep_en  = (state == ST_INIT);
    lookup_en = (state == ST_READY) && pred_req;
    update_en = (state == ST_READY) && upd_valid;
    repair_en = (state == ST_READY) && upd_valid && upd_mispredict;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sweep_ptr <= '0;
    end else if (sweep_en) begin
      sweep_ptr <= sweep_ptr + 1'b1;
    end
  end

  // Table has no reset: the sweep clears it, and a lookup in the same cycle sees the old counter.
  always_ff @(posedge clock) begin
    if (sweep_en) begin
      table_q[sweep_ptr] <= 2'b00;
    end else if (update_en) begin
      table_q[upd_index] <= upd_ctr_next;
    end
  end

  always_comb begin
    upd_ctr    = table_q[upd_index];
    lookup_dir = table_q[ghr][1];
    if (upd_taken) begin
      upd_ctr_next = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'b01;
    end else begin
      upd_ctr_next = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'b01;
    end
  end

  // Mispredict repair takes priority over the speculative shift.
  always_comb begin
    ghr_next = ghr;
    if (repair_en) begin
      ghr_next = {upd_index[HIST_BITS-2:0], upd_taken};
    end else if (lookup_en) begin
      ghr_next = {ghr[HIST_BITS-2:0], lookup_dir};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ghr <= '0;
    end else begin
      ghr <= ghr_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_index <= '0;
    end else begin
      pred_valid <= lookup_en;
      if (lookup_en) begin
        pred_taken <= lookup_dir;
        pred_index <= ghr;
      end
    end
  end

endmodule

// File: tb/tb_global_history_predictor.sv
// tb/tb_global_history_predictor.sv - directed bench for global_history_predictor
// Runs with HIST_BITS=4; expected values are hand-computed per step.
module tb_global_history_predictor;

  localparam int HB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          ready;
  logic          pred_req;
  logic          pred_valid;
  logic          pred_taken;
  logic [HB-1:0] pred_index;
  logic          upd_valid;
  logic [HB-1:0] upd_index;
  logic          upd_taken;
  logic          upd_mispredict;

  int vectors = 0;
  int miscompares = 0;

  global_history_predictor #(.HIST_BITS(HB)) dut (
    .clock          (clock),
    .reset          (reset),
    .ready          (ready),
    .pred_req       (pred_req),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_index     (pred_index),
    .upd_valid      (upd_valid),
    .upd_index      (upd_index),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic upd(input logic [HB-1:0] idx, input logic taken, input logic mp);
    upd_valid      = 1'b1;
    upd_index      = idx;
    upd_taken      = taken;
    upd_mispredict = mp;
    tick();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic lookup(input string tag, input int exp_idx, input int exp_taken);
    pred_req = 1'b1;
    tick();
    pred_req = 1'b0;
    check({tag, ".valid"}, int'(pred_valid), 1);
    check({tag, ".index"}, int'(pred_index), exp_idx);
    check({tag, ".taken"}, int'(pred_taken), exp_taken);
  endtask

  task automatic check_sweep(input string tag);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("%s.ready_e%0d", tag, i), int'(ready), (i == 16) ? 1 : 0);
      check($sformatf("%s.pvalid_e%0d", tag, i), int'(pred_valid), 0);
    end
  endtask

  initial begin
    reset          = 1'b1;
    pred_req       = 1'b1;
    upd_valid      = 1'b0;
    upd_index      = '0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
    #3;
    check("rst.ready", int'(ready), 0);
    check("rst.pvalid", int'(pred_valid), 0);
    check("rst.ptaken", int'(pred_taken), 0);
    check("rst.pindex", int'(pred_index), 0);
    tick();
    tick();
    reset = 1'b0;

    // 1: sweep with pred_req held high; first READY lookup
    check_sweep("sweep");
    lookup("first", 0, 0);

    // 2: training and saturation on entry 5 (repairs via entry A give GHR=5)
    upd(4'h5, 1'b1, 1'b0);
    upd(4'h5, 1'b1, 1'b0);
    upd(4'hA, 1'b1, 1'b1);
    lookup("train2", 5, 1);
    upd(4'h5, 1'b1, 1'b0);
    upd(4'h5, 1'b1, 1'b0);
    upd(4'h5, 1'b0, 1'b0);
    upd(4'hA, 1'b1, 1'b1);
    lookup("train_sat_dec", 5, 1);
    upd(4'h5, 1'b0, 1'b0);
    upd(4'h5, 1'b0, 1'b0);
    upd(4'h5, 1'b0, 1'b0);
    upd(4'hA, 1'b1, 1'b1);
    lookup("train_zero", 5, 0);
    upd(4'h5, 1'b0, 1'b0);
    upd(4'hA, 1'b1, 1'b1);
    lookup("train_floor", 5, 0);

    // 3: speculative shift; entries 0 and 1 taken, GHR repaired to 0
    upd(4'h0, 1'b1, 1'b0);
    upd(4'h0, 1'b1, 1'b0);
    upd(4'h0, 1'b1, 1'b0);
    upd(4'h1, 1'b1, 1'b0);
    upd(4'h1, 1'b1, 1'b0);
    upd(4'h8, 1'b0, 1'b1);
    pred_req = 1'b1;
    tick();
    check("spec0.index", int'(pred_index), 0);
    check("spec0.taken", int'(pred_taken), 1);
    tick();
    check("spec1.valid", int'(pred_valid), 1);
    check("spec1.index", int'(pred_index), 1);
    check("spec1.taken", int'(pred_taken), 1);
    tick();
    check("spec2.index", int'(pred_index), 3);
    check("spec2.taken", int'(pred_taken), 0);
    pred_req = 1'b0;
    lookup("spec_final", 6, 0);

    // 4: mispredict repair, then a non-mispredict update leaves GHR alone
    upd(4'hA, 1'b1, 1'b1);
    lookup("repair", 5, 0);
    upd(4'hA, 1'b1, 1'b0);
    lookup("no_repair", 4'hA, 1);

    // 5: collision of lookup and mispredict update on entry 2
    upd(4'h2, 1'b1, 1'b0);
    upd(4'h1, 1'b0, 1'b1);
    pred_req       = 1'b1;
    upd_valid      = 1'b1;
    upd_index      = 4'h2;
    upd_taken      = 1'b1;
    upd_mispredict = 1'b1;
    tick();
    pred_req       = 1'b0;
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
    check("coll.valid", int'(pred_valid), 1);
    check("coll.index", int'(pred_index), 2);
    check("coll.taken", int'(pred_taken), 0);
    lookup("coll_ghr", 5, 0);
    upd(4'h1, 1'b0, 1'b1);
    lookup("coll_ctr", 2, 1);

    // 6: reset mid-operation
    upd(4'h7, 1'b1, 1'b0);
    upd(4'h7, 1'b1, 1'b0);
    upd(4'h7, 1'b1, 1'b0);
    check("pulse.pvalid", int'(pred_valid), 0);
    reset = 1'b1;
    #1;
    check("mid.ready", int'(ready), 0);
    check("mid.pvalid", int'(pred_valid), 0);
    check("mid.ptaken", int'(pred_taken), 0);
    check("mid.pindex", int'(pred_index), 0);
    tick();
    reset = 1'b0;
    check_sweep("resweep");
    upd(4'h3, 1'b1, 1'b1);
    lookup("after_reset", 7, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
